hazard_forward_unit: RTL

- Hazard and forwarding controller for the 5-stage MIPS pipeline with jal/jr support.
- Keeps its own shadow copy of destination-register info for EX/MEM/WB.
- Drives the registered 2-bit selects of the EX-stage 3:1 operand muxes, the load-use stall, and jr resolution in ID (stall, then IF flush).

---
 rtl/hazard_pkg.sv | 50 +++++
 rtl/hazard_dest_pipe.sv | 41 ++++
 rtl/hazard_forward_unit.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard / forwarding controller.
// Holds the forward-select encodings, the jr FSM states, the shadow-entry
// record and the register-match helpers used by the top and the shadow pipe.
package hazard_pkg;

    localparam int HZ_REG_W = 5;

    // EX-stage operand mux select encodings (2'b11 is never produced)
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        JR_WAIT = 1'b1
    } hz_state_e;

    // Destination info tracked for every in-flight instruction
    typedef struct packed {
        logic [HZ_REG_W-1:0] dst;
        logic                wr;
        logic                ld;
    } shadow_t;

    localparam shadow_t SHADOW_BUBBLE = '0;

    // True when a stage writes register r; $0 never matches
    function automatic logic writes_reg(
        input logic                wr,
        input logic [HZ_REG_W-1:0] dst,
        input logic [HZ_REG_W-1:0] r
    );
        return wr && (dst == r) && (r != '0);
    endfunction

    // Youngest producer wins: EX producer -> MEM value, MEM producer -> WB value
    function automatic logic [1:0] fwd_select(
        input logic                use_src,
        input logic [HZ_REG_W-1:0] src,
        input logic                ex_wr,
        input logic [HZ_REG_W-1:0] ex_dst,
        input logic                mem_wr,
        input logic [HZ_REG_W-1:0] mem_dst
    );
        if (use_src && writes_reg(ex_wr, ex_dst, src)) return FWD_MEM;
        if (use_src && writes_reg(mem_wr, mem_dst, src)) return FWD_WB;
        return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_dest_pipe.sv
// Three-stage shadow chain of destination info (EX -> MEM -> WB).
// A bubble is inserted into EX whenever ID does not advance.
module hazard_dest_pipe
    import hazard_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    id_take,
    input  shadow_t id_entry,
    output shadow_t ex_entry,
    output shadow_t mem_entry,
    output shadow_t wb_entry
);

    shadow_t ex_d, ex_q, mem_d, mem_q, wb_d, wb_q;

    // Next-stage values: EX takes the ID instruction or a bubble
    always_comb begin
        ex_d  = id_take ? id_entry : SHADOW_BUBBLE;
        mem_d = ex_q;
        wb_d  = mem_q;
    end

    // Shadow register chain, cleared by asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= SHADOW_BUBBLE;
            mem_q <= SHADOW_BUBBLE;
            wb_q  <= SHADOW_BUBBLE;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    assign ex_entry  = ex_q;
    assign mem_entry = mem_q;
    assign wb_entry  = wb_q;

endmodule

// File: rtl/hazard_forward_unit.sv
// Hazard and forwarding controller for a 5-stage MIPS pipeline (jal/jr).
// Produces registered EX operand-mux selects, the load-use stall and jr
// resolution in ID (stall until the target is in the register file, then
// release jr_go together with an IF flush).
// Optional build macro HAZARD_STATS_EN adds stall_count / jr_count outputs.
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_W        = HZ_REG_W,
    parameter int JR_MAX_STALL = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_is_jr,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic             stall,
    output logic             flush_if,
    output logic             jr_go
`ifdef HAZARD_STATS_EN
    ,
    output logic [31:0]      stall_count,
    output logic [15:0]      jr_count
`endif
);

    localparam int CNT_W = (JR_MAX_STALL > 2) ? $clog2(JR_MAX_STALL) : 1;
    localparam logic [CNT_W-1:0] CNT_EX_LOAD = CNT_W'(JR_MAX_STALL - 1);

    shadow_t          id_entry, ex_e, mem_e, wb_unused;
    logic             mem_ld_unused;
    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    logic             stall_raw, jr_go_raw, load_use, jr_hazard;
    logic             wait_done, evaluate, id_take, rs_in_ex, rs_in_mem;

    assign id_entry      = '{dst: id_dst, wr: id_reg_write, ld: id_mem_read};
    assign mem_ld_unused = mem_e.ld;
    assign id_take       = id_valid && !stall_raw;

    hazard_dest_pipe u_dest_pipe (
        .clk       (clk),
        .rst       (reset),
        .id_take   (id_take),
        .id_entry  (id_entry),
        .ex_entry  (ex_e),
        .mem_entry (mem_e),
        .wb_entry  (wb_unused)
    );

    // jr FSM next state, load-use detection and jr resolution.
    // The last JR_WAIT cycle (cnt == 0) re-evaluates the jr exactly like RUN:
    // by then the producer has reached WB, so the jr is released there and
    // the total stall equals the producer's distance from WB.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load_use  = 1'b0;
        jr_hazard = 1'b0;
        jr_go_raw = 1'b0;
        wait_done = (state_q == JR_WAIT) && (cnt_q == '0);
        evaluate  = (state_q == RUN) || wait_done;
        rs_in_ex  = writes_reg(ex_e.wr, ex_e.dst, id_rs);
        rs_in_mem = writes_reg(mem_e.wr, mem_e.dst, id_rs);

        if (state_q == JR_WAIT) begin
            if (wait_done) state_d = RUN;
            else           cnt_d   = cnt_q - CNT_W'(1);
        end

        if (evaluate && id_valid) begin
            load_use = ex_e.ld &&
                       ((id_use_rs && writes_reg(ex_e.wr, ex_e.dst, id_rs)) ||
                        (id_use_rt && writes_reg(ex_e.wr, ex_e.dst, id_rt)));
            if (id_is_jr) begin
                if (rs_in_ex) begin
                    jr_hazard = 1'b1;
                    cnt_d     = CNT_EX_LOAD;
                    state_d   = JR_WAIT;
                end else if (rs_in_mem) begin
                    jr_hazard = 1'b1;
                    cnt_d     = '0;
                    state_d   = JR_WAIT;
                end else if (!load_use) begin
                    jr_go_raw = 1'b1;
                end
            end
        end

        stall_raw = ((state_q == JR_WAIT) && !wait_done) || load_use || jr_hazard;
    end

    // Forward selects for the instruction entering EX; bubbles get register file
    always_comb begin
        fwd_a_d = FWD_REG;
        fwd_b_d = FWD_REG;
        if (id_take) begin
            fwd_a_d = fwd_select(id_use_rs, id_rs, ex_e.wr, ex_e.dst, mem_e.wr, mem_e.dst);
            fwd_b_d = fwd_select(id_use_rt, id_rt, ex_e.wr, ex_e.dst, mem_e.wr, mem_e.dst);
        end
    end

    // FSM, wait counter and registered selects
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= RUN;
            cnt_q   <= '0;
            fwd_a_q <= FWD_REG;
            fwd_b_q <= FWD_REG;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // Combinational controls are forced low while reset is held
    assign stall     = stall_raw & ~reset;
    assign jr_go     = jr_go_raw & ~reset;
    assign flush_if  = jr_go_raw & ~reset;
    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;

`ifdef HAZARD_STATS_EN
    logic [31:0] stall_count_q, stall_count_d;
    logic [15:0] jr_count_q, jr_count_d;

    // Stall counter wraps; jr counter saturates
    always_comb begin
        stall_count_d = stall_count_q + {31'd0, stall_raw};
        jr_count_d    = jr_count_q;
        if (jr_go_raw && (jr_count_q != 16'hFFFF)) jr_count_d = jr_count_q + 16'd1;
    end

    // Statistics registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            jr_count_q    <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            jr_count_q    <= jr_count_d;
        end
    end

    assign stall_count = stall_count_q;
    assign jr_count    = jr_count_q;
`endif

endmodule
